quick_spi_sequencer: RTL

QUICK_SPI_SEQUENCER -- requirements
Module: quick_spi_sequencer

---
 rtl/quick_spi_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/quick_spi_sequencer.sv
// ---------------------------------------------------------------------------
// quick_spi_sequencer
//
// Queues SPI commands and replays them one at a time to an external SPI
// master. Each popped command yields exactly one response, either carrying
// the read data returned by the master or flagging a timeout.
//
// Ports
//   clk                 single clock, all logic on the rising edge
//   reset               synchronous, active-high
//   cmd_valid/ready     command push handshake (ready = queue not full)
//   cmd_slave           slave select field of the command
//   cmd_operation       0 = READ, 1 = WRITE
//   cmd_data            outgoing payload
//   start_transaction   one-cycle strobe to the SPI master
//   slave/operation/
//   outgoing_data       command fields presented to the master while it is
//                       working on the command, zero otherwise
//   end_of_transaction  completion strobe from the master
//   incoming_data       read result from the master
//   rsp_valid/ready     response handshake
//   rsp_data            read data (0 for WRITE or timeout)
//   rsp_operation       echoed operation of the answered command
//   rsp_timeout         master did not complete within TIMEOUT_CYCLES
//   fifo_level          number of queued commands
//   busy                sequencer not idle or commands still queued
// ---------------------------------------------------------------------------
module quick_spi_sequencer #(
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int CMD_FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES      = 1024,
  parameter int GAP_CYCLES          = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [NUMBER_OF_SLAVES-1:0]         cmd_slave,
  input  logic                                cmd_operation,
  input  logic [OUTGOING_DATA_WIDTH-1:0]      cmd_data,
  output logic                                start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]         slave,
  output logic                                operation,
  output logic [OUTGOING_DATA_WIDTH-1:0]      outgoing_data,
  input  logic                                end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0]      incoming_data,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [INCOMING_DATA_WIDTH-1:0]      rsp_data,
  output logic                                rsp_operation,
  output logic                                rsp_timeout,
  output logic [$clog2(CMD_FIFO_DEPTH):0]     fifo_level,
  output logic                                busy
);

  localparam int PTR_W   = $clog2(CMD_FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = NUMBER_OF_SLAVES + 1 + OUTGOING_DATA_WIDTH;
  // One counter serves both the end-of-transaction wait and the gap.
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + 1) + 1;

  localparam logic [LVL_W-1:0] FULL_LEVEL   = LVL_W'(CMD_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_EOT = 3'd2,
    ST_RESPOND  = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Command queue storage
  logic [ENTRY_W-1:0] r_mem [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [ENTRY_W-1:0] w_head;
  logic               w_push;
  logic               w_pop;

  // Command currently owned by the sequencer
  logic [NUMBER_OF_SLAVES-1:0]    r_hold_slave;
  logic                           r_hold_op;
  logic [OUTGOING_DATA_WIDTH-1:0] r_hold_data;

  // Response registers
  logic [INCOMING_DATA_WIDTH-1:0] r_rsp_data;
  logic                           r_rsp_operation;
  logic                           r_rsp_timeout;

  logic [CNT_W-1:0]               r_cnt;
  logic [CNT_W-1:0]               w_cnt_next;
  logic                           w_rsp_load;
  logic                           w_rsp_timeout_next;
  logic [INCOMING_DATA_WIDTH-1:0] w_rsp_data_next;
  logic                           w_drive;

  // ---------------------------------------------------------------------
  // Command queue. Ready is derived from the registered level only, so a
  // full queue refuses a push even in a cycle where the head is popped.
  // ---------------------------------------------------------------------
  assign cmd_ready = (r_level != FULL_LEVEL);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_slave, cmd_operation, cmd_data};
    end
  end

  // Depth is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Holding registers capture the head at the moment it is popped.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      {r_hold_slave, r_hold_op, r_hold_data} <= w_head;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM: next state and control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_pop              = 1'b0;
    w_rsp_load         = 1'b0;
    w_rsp_timeout_next = 1'b0;
    w_rsp_data_next    = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_cnt_next   = '0;
        w_state_next = ST_WAIT_EOT;
      end

      ST_WAIT_EOT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (end_of_transaction) begin
          w_rsp_load      = 1'b1;
          w_rsp_data_next = r_hold_op ? '0 : incoming_data;
          w_state_next    = ST_RESPOND;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_rsp_load         = 1'b1;
          w_rsp_timeout_next = 1'b1;
          w_state_next       = ST_RESPOND;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_RESPOND: begin
        if (rsp_ready) begin
          w_cnt_next   = '0;
          w_state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Response registers: stay stable from capture until the next capture.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_data      <= '0;
      r_rsp_operation <= 1'b0;
      r_rsp_timeout   <= 1'b0;
    end else if (w_rsp_load) begin
      r_rsp_data      <= w_rsp_data_next;
      r_rsp_operation <= r_hold_op;
      r_rsp_timeout   <= w_rsp_timeout_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. Command fields are only driven while the master owns the
  // command, so the bus reads zero in every other state (and after reset).
  // ---------------------------------------------------------------------
  assign w_drive           = (r_state == ST_ISSUE) || (r_state == ST_WAIT_EOT);
  assign start_transaction = (r_state == ST_ISSUE);
  assign slave             = w_drive ? r_hold_slave : '0;
  assign operation         = w_drive ? r_hold_op    : 1'b0;
  assign outgoing_data     = w_drive ? r_hold_data  : '0;

  assign rsp_valid     = (r_state == ST_RESPOND);
  assign rsp_data      = r_rsp_data;
  assign rsp_operation = r_rsp_operation;
  assign rsp_timeout   = r_rsp_timeout;

  assign fifo_level = r_level;
  assign busy       = (r_state != ST_IDLE) || (r_level != '0);

endmodule
